// File: rtl/seg7_display_driver.sv
// seg7_display_driver: shows a captured 16-bit word as 4 hex digits on a multiplexed
// common-anode 7-segment display, with optional leading-zero blanking.
module seg7_display_driver #(
    parameter int REFRESH_DIV     = 100000,
    parameter bit LEAD_ZERO_BLANK = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CMAX = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   disp_q, disp_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d, frame_done_q, frame_done_d;
    logic          wrap, dark, off;
    logic [3:0]    nib;
    always_comb begin
        wrap         = cnt_q == CMAX;
        cnt_d        = wrap ? '0 : cnt_q + 1'b1;
        dig_d        = wrap ? dig_q + 2'd1 : dig_q;
        disp_d       = load ? data_in : disp_q;
        nib          = disp_q[{dig_q, 2'b00} +: 4];
        // a digit is a leading zero when it and every higher nibble are zero
        dark         = LEAD_ZERO_BLANK && dig_q != 2'd0 && (disp_q >> {dig_q, 2'b00}) == 16'd0;
        off          = blank || dark;
        an_d         = off ? 4'hF : ~(4'b0001 << dig_q);
        seg_d        = off ? 7'h7F : HEX[nib];
        dp_d         = off || dig_q != 2'd2;
        frame_done_d = wrap && dig_q == 2'd3;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            dig_q        <= 2'd0;
            disp_q       <= 16'd0;
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            disp_q       <= disp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_display_driver.sv
// tb_seg7_display_driver: directed frames with hand-computed segment patterns, checked
// through an expectation queue drained by an independent monitor.
module tb_seg7_display_driver;
    logic        clk = 1'b0, reset = 1'b0, load = 1'b0, blank = 1'b0;
    logic [15:0] data_in = 16'd0;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fd0, fd1;
    typedef struct {
        string       nm;
        logic [11:0] e0;
        logic [11:0] e1;
    } exp_t;
    exp_t q[$];
    int compared = 0, mismatched = 0;
    localparam logic [11:0] RST = {4'hF, 7'h7F, 1'b1, 1'b0};

    seg7_display_driver #(.REFRESH_DIV(4), .LEAD_ZERO_BLANK(1'b0)) u0 (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load), .blank(blank),
        .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0));
    seg7_display_driver #(.REFRESH_DIV(4), .LEAD_ZERO_BLANK(1'b1)) u1 (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load), .blank(blank),
        .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1));

    always #5 clk = ~clk;

    task automatic check(input string nm, input string u, input logic [11:0] act, input logic [11:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s %s: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                     nm, u, act[11:8], act[7:1], act[1], act[0], exp[11:8], exp[7:1], exp[1], exp[0]);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check(e.nm, "lzb0", {an0, seg0, dp0, fd0}, e.e0);
                check(e.nm, "lzb1", {an1, seg1, dp1, fd1}, e.e1);
            end
        end
    end

    function automatic logic [11:0] ex(input logic lit, input logic [1:0] d, input logic [6:0] s, input logic fd);
        return lit ? {~(4'b0001 << d), s, d != 2'd2, fd} : {4'hF, 7'h7F, 1'b1, fd};
    endfunction

    task automatic cyc(input string nm, input logic [11:0] e0, input logic [11:0] e1);
        @(posedge clk);
        #1;
        q.push_back('{nm, e0, e1});
    endtask

    task automatic frame(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] lit1,
                         input logic [15:0] nd, input logic nl, input int bs, input int be,
                         input int lk, input logic [15:0] ld, input logic [6:0] alt);
        logic [6:0] s [4];
        logic [6:0] sv;
        logic [1:0] d;
        logic       fd;
        s = '{s0, s1, s2, s3};
        for (int k = 0; k < 16; k++) begin
            d     = 2'(k / 4);
            fd    = k == 15;
            blank = k >= bs && k <= be;
            if (k == lk) begin
                load    = 1'b1;
                data_in = ld;
            end
            if (k == 15) begin
                load    = nl;
                data_in = nd;
            end
            sv = (lk >= 0 && k > lk && int'(d) == lk / 4) ? alt : s[d];
            cyc(nm, blank ? ex(1'b0, d, sv, fd) : ex(1'b1, d, sv, fd),
                    blank ? ex(1'b0, d, sv, fd) : ex(lit1[d], d, sv, fd));
            load = 1'b0;
        end
    endtask

    initial begin
        repeat (3) cyc("reset", RST, RST);
        reset = 1'b1;
        frame("zero",  7'h40, 7'h40, 7'h40, 7'h40, 4'b0001, 16'hA53C, 1'b1, -1, -1, -1, 16'h0, 7'h0);
        frame("a53c",  7'h46, 7'h30, 7'h12, 7'h08, 4'b1111, 16'hFFFF, 1'b0, -1, -1, -1, 16'h0, 7'h0);
        frame("hold",  7'h46, 7'h30, 7'h12, 7'h08, 4'b1111, 16'h0007, 1'b1, -1, -1, -1, 16'h0, 7'h0);
        frame("0007",  7'h78, 7'h40, 7'h40, 7'h40, 4'b0001, 16'h0100, 1'b1, -1, -1, -1, 16'h0, 7'h0);
        frame("0100",  7'h40, 7'h40, 7'h79, 7'h40, 4'b0111, 16'h0000, 1'b1, -1, -1, -1, 16'h0, 7'h0);
        frame("0000",  7'h40, 7'h40, 7'h40, 7'h40, 4'b0001, 16'h0D8B, 1'b1, -1, -1, -1, 16'h0, 7'h0);
        frame("0d8b",  7'h03, 7'h00, 7'h21, 7'h40, 4'b0111, 16'h2469, 1'b1, -1, -1, -1, 16'h0, 7'h0);
        frame("2469",  7'h10, 7'h02, 7'h19, 7'h24, 4'b1111, 16'h0000, 1'b0, -1, -1, -1, 16'h0, 7'h0);
        frame("blank", 7'h10, 7'h02, 7'h19, 7'h24, 4'b1111, 16'h0000, 1'b0,  5,  9, -1, 16'h0, 7'h0);
        frame("midld", 7'h10, 7'h02, 7'h19, 7'h24, 4'b1111, 16'h0000, 1'b0, -1, -1,  5, 16'h24E9, 7'h06);
        frame("24e9",  7'h10, 7'h06, 7'h19, 7'h24, 4'b1111, 16'h0000, 1'b0, -1, -1, -1, 16'h0, 7'h0);
        for (int k = 0; k < 6; k++)
            cyc("prerst", ex(1'b1, 2'(k / 4), k < 4 ? 7'h10 : 7'h06, 1'b0),
                          ex(1'b1, 2'(k / 4), k < 4 ? 7'h10 : 7'h06, 1'b0));
        @(posedge clk);
        #3;
        reset   = 1'b0;
        load    = 1'b1;
        data_in = 16'hBEEF;
        q.push_back('{"async_rst", RST, RST});
        repeat (2) cyc("in_rst", RST, RST);
        load  = 1'b0;
        reset = 1'b1;
        frame("post",  7'h40, 7'h40, 7'h40, 7'h40, 4'b0001, 16'h0000, 1'b0, -1, -1, -1, 16'h0, 7'h0);
        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seg7_display_driver.md
Name: seg7_display_driver

Overview:
- Downstream board-output stage for the 8-bit datapath.
- Consumes the datapath's 16-bit debug word {writeback byte, register byte} and shows it as 4 hex digits on a time-multiplexed common-anode 7-segment display.
- Holds a captured copy of the word, scans digits with a refresh counter, and optionally blanks leading zeros.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit is lit; legal range >= 2.
- LEAD_ZERO_BLANK, 0: 1 = suppress leading zero digits 3..1; digit 0 is always shown.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = in reset
- data_in  in  16  datapath output word; [15:8] writeback, [7:0] register data
- load  in  1  capture data_in into the display register on this clock
- blank  in  1  force all digits dark while high
- an  out  4  digit anodes, active-low; bit i = digit i, digit 0 rightmost
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}
- dp  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse per completed 4-digit scan

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - disp_q=0, refresh counter=0, digit index=0.
  - an=4'b1111, seg=7'h7F, dp=1, frame_done=0.
- Capture:
  - disp_q<=data_in on any clock with load=1; otherwise disp_q holds.
  - data_in is ignored when load=0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 each clock, then wraps to 0.
  - On the wrap edge, digit index advances 0->1->2->3->0.
  - Each digit therefore lasts exactly REFRESH_DIV cycles.
- frame_done: registered; high for the single cycle following the edge where digit index wraps 3->0.
- Nibble select: digit i shows disp_q[4i+3:4i].
- Registered outputs: an, seg and dp are computed from the current digit index and disp_q and registered. They lag the internal state by 1 cycle, with no combinational glitches.
  - an: one-hot low for the active digit.
  - dp: 0 only when digit 2 is active (separates the high byte from the low byte); 1 otherwise.
- Hex encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking (LEAD_ZERO_BLANK=1):
  - Digit i (i>=1) is dark when its nibble and all higher nibbles are zero.
  - Dark means an bit=1, seg=7'h7F, dp=1.
  - Digit 0 is never blanked.
- blank=1:
  - Next clock: an=4'b1111, seg=7'h7F, dp=1.
  - Counter, digit index and capture continue unaffected.
  - On release, output resumes at whatever digit is current.
- Simultaneous load and digit advance: both take effect; the next registered output shows the new digit with the new data.
- Load mid-digit: seg reflects the new nibble 1 cycle after the capture edge, with no change to scan timing.
- Reset mid-scan: outputs go to reset values immediately. After release, the scan restarts at digit 0, counter 0.

Test Plan:
- Sim setup: REFRESH_DIV=4, LEAD_ZERO_BLANK=0 unless stated.
- Reset then release with load=0 -> 1 clock after release: an=1110, seg=1000000, dp=1; an stays 1110 for 4 cycles, then 1101.
- load=1 for 1 cycle with data_in=16'hA53C -> over the next 16 cycles:
  - an=1110 seg=1000110
  - an=1101 seg=0110000
  - an=1011 seg=0010010 dp=0
  - an=0111 seg=0001000
  - frame_done pulses once after the digit-3 slot ends.
- After loading 16'hA53C, drive data_in=16'hFFFF with load=0 -> display still shows A53C over a full frame.
- LEAD_ZERO_BLANK=1:
  - Load 16'h0007 -> an=1111 during the digit 3/2/1 slots; digit 0 slot shows an=1110, seg=1111000.
  - Load 16'h0000 -> only digit 0 shows 0.
  - Load 16'h0100 -> digits 2..0 lit, digit 3 dark.
- Assert blank during the digit-1 slot -> next cycle an=1111. Release 5 cycles later -> an=1011 (digit 2 active, counter unaffected).
- Pull reset low mid-frame between clock edges -> an=1111, seg=7F, frame_done=0 with no clock edge. After release, the scan restarts at digit 0 and disp_q=0.
